// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared state encoding and defaults for the convolution PE scheduler
package conv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    DRAIN,
    WRITE,
    DONE
  } sched_state_t;

  localparam int PSUM_W_DEF = 32;
  localparam int ZERO_CNT_W = 16;

  // Output feature-map extent along one axis for a valid (unpadded) convolution
  function automatic int out_dim(input int img, input int k);
    return img - k + 1;
  endfunction

endpackage

// File: rtl/conv_addr_gen.sv
// rtl/conv_addr_gen.sv - output-pixel and kernel-tap counters with buffer address generation
module conv_addr_gen
  import conv_pkg::*;
#(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int K      = 3,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              step_tap,
  input  logic              step_pixel,
  output logic [ADDR_W-1:0] ifmap_addr,
  output logic [ADDR_W-1:0] wt_addr,
  output logic [ADDR_W-1:0] ofmap_addr,
  output logic              last_tap,
  output logic              last_pixel
);

  localparam int OW = out_dim(IMG_W, K);
  localparam int OH = out_dim(IMG_H, K);

  localparam logic [ADDR_W-1:0] K_A      = ADDR_W'(K);
  localparam logic [ADDR_W-1:0] K_LAST   = ADDR_W'(K - 1);
  localparam logic [ADDR_W-1:0] IMG_W_A  = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] OW_A     = ADDR_W'(OW);
  localparam logic [ADDR_W-1:0] OW_LAST  = ADDR_W'(OW - 1);
  localparam logic [ADDR_W-1:0] OH_LAST  = ADDR_W'(OH - 1);

  logic [ADDR_W-1:0] kx;
  logic [ADDR_W-1:0] ky;
  logic [ADDR_W-1:0] ox;
  logic [ADDR_W-1:0] oy;

  // Kernel tap walk: kx fastest, both wrap to 0 after the last tap so the next pixel starts clean
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      kx <= '0;
      ky <= '0;
    end else if (step_tap) begin
      if (kx == K_LAST) begin
        kx <= '0;
        ky <= (ky == K_LAST) ? '0 : ky + 1'b1;
      end else begin
        kx <= kx + 1'b1;
      end
    end
  end

  // Output pixel walk in raster order: ox fastest, both wrap to 0 after the last pixel
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      ox <= '0;
      oy <= '0;
    end else if (step_pixel) begin
      if (ox == OW_LAST) begin
        ox <= '0;
        oy <= (oy == OH_LAST) ? '0 : oy + 1'b1;
      end else begin
        ox <= ox + 1'b1;
      end
    end
  end

  assign ifmap_addr = (oy + ky) * IMG_W_A + (ox + kx);
  assign wt_addr    = ky * K_A + kx;
  assign ofmap_addr = oy * OW_A + ox;
  assign last_tap   = (kx == K_LAST) && (ky == K_LAST);
  assign last_pixel = (ox == OW_LAST) && (oy == OH_LAST);

endmodule

// File: rtl/conv_pe_scheduler.sv
// rtl/conv_pe_scheduler.sv - sequences one binary-MAC PE over a feature map; optional ZERO_SKIP_STATS_EN adds zero_tap_cnt
module conv_pe_scheduler
  import conv_pkg::*;
#(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int K      = 3,
  parameter int PSUM_W = PSUM_W_DEF,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ifmap_addr,
  input  logic              ifmap_rd_data,
  output logic [ADDR_W-1:0] wt_addr,
  input  logic              wt_rd_data,
  output logic [PSUM_W-1:0] pe_inpsum,
  output logic              pe_weight,
  output logic              pe_infmap,
  input  logic [PSUM_W-1:0] pe_outpsum,
  output logic              ofmap_valid,
  input  logic              ofmap_ready,
  output logic [ADDR_W-1:0] ofmap_addr,
  output logic [PSUM_W-1:0] ofmap_data
`ifdef ZERO_SKIP_STATS_EN
  ,
  output logic [ZERO_CNT_W-1:0] zero_tap_cnt
`endif
);

  sched_state_t state_q;
  sched_state_t state_d;

  logic [PSUM_W-1:0] psum_reg;
  logic              data_valid;
  logic              last_tap;
  logic              last_pixel;
  logic              step_tap;
  logic              step_pixel;
  logic              accept_start;
  logic              enter_issue;

  conv_addr_gen #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .K      (K),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk        (clk),
    .reset      (reset),
    .clear      (accept_start),
    .step_tap   (step_tap),
    .step_pixel (step_pixel),
    .ifmap_addr (ifmap_addr),
    .wt_addr    (wt_addr),
    .ofmap_addr (ofmap_addr),
    .last_tap   (last_tap),
    .last_pixel (last_pixel)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and control decode
  always_comb begin
    state_d      = state_q;
    busy         = 1'b0;
    done         = 1'b0;
    ofmap_valid  = 1'b0;
    step_tap     = 1'b0;
    step_pixel   = 1'b0;
    accept_start = 1'b0;
    enter_issue  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept_start = 1'b1;
          enter_issue  = 1'b1;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        busy     = 1'b1;
        step_tap = 1'b1;
        if (last_tap) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        busy    = 1'b1;
        state_d = WRITE;
      end
      WRITE: begin
        busy        = 1'b1;
        ofmap_valid = 1'b1;
        if (ofmap_ready) begin
          step_pixel = 1'b1;
          if (last_pixel) begin
            state_d = DONE;
          end else begin
            enter_issue = 1'b1;
            state_d     = ISSUE;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Buffers answer one cycle after the address, so mark the returning-data cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      data_valid <= 1'b0;
    end else begin
      data_valid <= (state_q == ISSUE);
    end
  end

  // Partial-sum chain; a zero ifmap bit holds the sum because the PE gates its output to 0
  always_ff @(posedge clk) begin
    if (reset) begin
      psum_reg <= '0;
    end else if (enter_issue) begin
      psum_reg <= '0;
    end else if (data_valid && ifmap_rd_data) begin
      psum_reg <= pe_outpsum;
    end
  end

`ifdef ZERO_SKIP_STATS_EN
  // Zero-tap statistics for the current pass, saturating
  always_ff @(posedge clk) begin
    if (reset) begin
      zero_tap_cnt <= '0;
    end else if (accept_start) begin
      zero_tap_cnt <= '0;
    end else if (data_valid && !ifmap_rd_data && (zero_tap_cnt != {ZERO_CNT_W{1'b1}})) begin
      zero_tap_cnt <= zero_tap_cnt + 1'b1;
    end
  end
`endif

  assign pe_inpsum  = psum_reg;
  assign pe_weight  = wt_rd_data;
  assign pe_infmap  = ifmap_rd_data;
  assign ofmap_data = psum_reg;

endmodule
